// File: rtl/spi_pkg.sv
// Shared encodings for the SPI frame master: FSM state codes, SPI mode pairs
// and a counter-width helper.
package spi_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = IDLE,
      S_SETUP = SETUP,
      S_SHIFT = SHIFT,
      S_HOLD  = HOLD,
      S_GAP   = GAP
   } spi_state_t;

   // {CPOL, CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_frame_master_if.sv
// Parallel word handshake between the sample pipeline and the SPI frame master.
interface spi_frame_master_if #(
   parameter int FRAME_W = 16
);
   logic [FRAME_W-1:0] tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic [FRAME_W-1:0] rx_data;
   logic               rx_valid;

   modport master (output tx_data, output tx_valid, input tx_ready,
                   input rx_data, input rx_valid);
   modport slave  (input tx_data, input tx_valid, output tx_ready,
                   output rx_data, output rx_valid);
endinterface

// File: rtl/spi_frame_master_clk_gen.sv
// sclk generator: half-period counter plus edge counter; strobes mark the edge
// being taken this cycle so the FSM can act on the same enabled cycle.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int FRAME_W = 16,
   parameter int DIV     = 2,
   parameter bit CPOL    = 1'b0
) (
   input  logic clk,
   input  logic rst_a,
   input  logic ena,
   input  logic run,
   output logic sclk,
   output logic lead_stb,
   output logic trail_stb,
   output logic last_edge
);
   localparam int HC_W = cnt_w(DIV);
   localparam int EC_W = cnt_w(2 * FRAME_W);
   localparam logic [HC_W-1:0] HC_MAX = HC_W'(DIV - 1);
   localparam logic [EC_W-1:0] EC_MAX = EC_W'(2 * FRAME_W - 1);

   logic [HC_W-1:0] hc;
   logic [EC_W-1:0] ec;
   logic            tick;

   assign tick      = run & ena & (hc == HC_MAX);
   assign lead_stb  = tick & (sclk == CPOL);
   assign trail_stb = tick & (sclk != CPOL);
   assign last_edge = trail_stb & (ec == EC_MAX);

   always_ff @(posedge clk) begin
      if (rst_a) begin
         hc   <= '0;
         ec   <= '0;
         sclk <= CPOL;
      end else if (ena) begin
         if (!run) begin
            hc   <= '0;
            ec   <= '0;
            sclk <= CPOL;
         end else if (hc == HC_MAX) begin
            hc   <= '0;
            ec   <= ec + 1'b1;
            sclk <= ~sclk;
         end else begin
            hc <= hc + 1'b1;
         end
      end
   end
endmodule

// File: rtl/spi_frame_master.sv
// Chip-select framed SPI master: accepts a word over valid/ready, shifts it out
// on mosi while capturing miso, and returns the captured word with a strobe.
//
// state   | meaning
// IDLE    | cs_n high, tx_ready raised, waiting for a word
// SETUP   | cs_n low, sclk idle for CS_SETUP enabled cycles
// SHIFT   | 2*FRAME_W sclk edges, data out / sample in
// HOLD    | cs_n low, sclk idle for CS_HOLD enabled cycles
// GAP     | cs_n high for GAP enabled cycles before IDLE
module spi_frame_master
   import spi_pkg::*;
#(
   parameter int FRAME_W   = 16,
   parameter int DIV       = 2,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter int CS_SETUP  = 1,
   parameter int CS_HOLD   = 1,
   parameter int GAP       = 1,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic               clk,
   input  logic               rst_a,
   input  logic               ena,
   spi_frame_master_if.slave  bus,
   output logic               busy,
   output logic               sclk,
   output logic               cs_n,
   output logic               mosi,
   input  logic               miso
);
   if (DIV < 1)      begin : g_bad_div   $error("DIV must be >= 1");      end
   if (FRAME_W < 2)  begin : g_bad_fw    $error("FRAME_W must be >= 2");  end
   if (CS_SETUP < 1) begin : g_bad_setup $error("CS_SETUP must be >= 1"); end
   if (CS_HOLD < 1)  begin : g_bad_hold  $error("CS_HOLD must be >= 1");  end

   localparam int T_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > GAP) ? CS_SETUP : GAP)
                                               : ((CS_HOLD > GAP) ? CS_HOLD : GAP);
   localparam int T_W = cnt_w(T_MAX);
   localparam logic [T_W-1:0] T_SETUP = T_W'(CS_SETUP - 1);
   localparam logic [T_W-1:0] T_HOLD  = T_W'(CS_HOLD - 1);
   localparam logic [T_W-1:0] T_GAP   = T_W'(GAP - 1);

   spi_state_t         state;
   logic [T_W-1:0]     tmr;
   logic [FRAME_W-1:0] sh;
   logic [FRAME_W-1:0] sh_next;
   logic [FRAME_W-1:0] cap;
   logic [FRAME_W-1:0] cap_next;
   logic               lead_stb;
   logic               trail_stb;
   logic               last_edge;

   function automatic logic first_bit(input logic [FRAME_W-1:0] w);
      return LSB_FIRST ? w[0] : w[FRAME_W-1];
   endfunction

   assign sh_next  = LSB_FIRST ? (sh >> 1) : (sh << 1);
   assign cap_next = LSB_FIRST ? {miso, cap[FRAME_W-1:1]} : {cap[FRAME_W-2:0], miso};

   spi_clk_gen #(.FRAME_W(FRAME_W), .DIV(DIV), .CPOL(CPOL)) u_clk_gen (
      .clk       (clk),
      .rst_a     (rst_a),
      .ena       (ena),
      .run       (state == S_SHIFT),
      .sclk      (sclk),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb),
      .last_edge (last_edge)
   );

   always_ff @(posedge clk) begin
      // the strobe self-clears on the next clk edge even while ena is low
      bus.rx_valid <= 1'b0;
      if (rst_a) begin
         state       <= S_IDLE;
         tmr         <= '0;
         sh          <= '0;
         cap         <= '0;
         mosi        <= 1'b0;
         cs_n        <= 1'b1;
         busy        <= 1'b0;
         bus.tx_ready <= 1'b0;
         bus.rx_data  <= '0;
      end else if (ena) begin
         case (state)
            S_IDLE: begin
               if (bus.tx_ready && bus.tx_valid) begin
                  sh           <= bus.tx_data;
                  bus.tx_ready <= 1'b0;
                  cs_n         <= 1'b0;
                  busy         <= 1'b1;
                  tmr          <= T_SETUP;
                  state        <= S_SETUP;
                  if (!CPHA) mosi <= first_bit(bus.tx_data);
               end else begin
                  bus.tx_ready <= 1'b1;
               end
            end
            S_SETUP: begin
               if (tmr == '0) state <= S_SHIFT;
               else           tmr   <= tmr - 1'b1;
            end
            S_SHIFT: begin
               if (!CPHA) begin
                  if (lead_stb) cap <= cap_next;
                  if (trail_stb && !last_edge) begin
                     sh   <= sh_next;
                     mosi <= first_bit(sh_next);
                  end
               end else begin
                  if (lead_stb) begin
                     mosi <= first_bit(sh);
                     sh   <= sh_next;
                  end
                  if (trail_stb) cap <= cap_next;
               end
               if (last_edge) begin
                  tmr   <= T_HOLD;
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (tmr == '0) begin
                  cs_n         <= 1'b1;
                  mosi         <= 1'b0;
                  bus.rx_data  <= cap;
                  bus.rx_valid <= 1'b1;
                  if (GAP == 0) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     tmr   <= T_GAP;
                     state <= S_GAP;
                  end
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_GAP: begin
               if (tmr == '0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: six configurations share one clock and a
// negedge monitor that counts cs_n-low cycles, sclk edges, sampled mosi bits and strobes.
`timescale 1ns/1ps
module tb_spi_frame_master;
   import spi_pkg::*;

   localparam int N = 6;
   // 0: defaults  1..3: modes 1..3 with DIV=3  4: GAP=0  5: FRAME_W=12 LSB first
   localparam logic [N-1:0] CPOL_V = 6'b001100;
   localparam logic [N-1:0] CPHA_V = 6'b001010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst_v;
   logic [N-1:0] ena_v;
   logic [N-1:0] txv;
   logic [15:0]  txd [N];
   wire  [N-1:0] rdy, rxv, busy_v, sclk_v, cs_v, mosi_v;
   wire  [15:0]  rxd [N];

   spi_frame_master_if #(.FRAME_W(16)) b0 ();
   spi_frame_master_if #(.FRAME_W(16)) b1 ();
   spi_frame_master_if #(.FRAME_W(16)) b2 ();
   spi_frame_master_if #(.FRAME_W(16)) b3 ();
   spi_frame_master_if #(.FRAME_W(16)) b4 ();
   spi_frame_master_if #(.FRAME_W(12)) b5 ();

   spi_frame_master u0 (.clk(clk), .rst_a(rst_v[0]), .ena(ena_v[0]), .bus(b0.slave), .busy(busy_v[0]),
                        .sclk(sclk_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]), .miso(mosi_v[0]));
   spi_frame_master #(.DIV(3), .CPOL(MODE1[1]), .CPHA(MODE1[0])) u1 (.clk(clk), .rst_a(rst_v[1]),
                        .ena(ena_v[1]), .bus(b1.slave), .busy(busy_v[1]),
                        .sclk(sclk_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]), .miso(mosi_v[1]));
   spi_frame_master #(.DIV(3), .CPOL(MODE2[1]), .CPHA(MODE2[0])) u2 (.clk(clk), .rst_a(rst_v[2]),
                        .ena(ena_v[2]), .bus(b2.slave), .busy(busy_v[2]),
                        .sclk(sclk_v[2]), .cs_n(cs_v[2]), .mosi(mosi_v[2]), .miso(mosi_v[2]));
   spi_frame_master #(.DIV(3), .CPOL(MODE3[1]), .CPHA(MODE3[0])) u3 (.clk(clk), .rst_a(rst_v[3]),
                        .ena(ena_v[3]), .bus(b3.slave), .busy(busy_v[3]),
                        .sclk(sclk_v[3]), .cs_n(cs_v[3]), .mosi(mosi_v[3]), .miso(mosi_v[3]));
   spi_frame_master #(.GAP(0)) u4 (.clk(clk), .rst_a(rst_v[4]), .ena(ena_v[4]), .bus(b4.slave),
                        .busy(busy_v[4]), .sclk(sclk_v[4]), .cs_n(cs_v[4]), .mosi(mosi_v[4]), .miso(mosi_v[4]));
   spi_frame_master #(.FRAME_W(12), .LSB_FIRST(1'b1)) u5 (.clk(clk), .rst_a(rst_v[5]), .ena(ena_v[5]),
                        .bus(b5.slave), .busy(busy_v[5]),
                        .sclk(sclk_v[5]), .cs_n(cs_v[5]), .mosi(mosi_v[5]), .miso(mosi_v[5]));

   assign b0.tx_data = txd[0];        assign b0.tx_valid = txv[0];
   assign b1.tx_data = txd[1];        assign b1.tx_valid = txv[1];
   assign b2.tx_data = txd[2];        assign b2.tx_valid = txv[2];
   assign b3.tx_data = txd[3];        assign b3.tx_valid = txv[3];
   assign b4.tx_data = txd[4];        assign b4.tx_valid = txv[4];
   assign b5.tx_data = txd[5][11:0];  assign b5.tx_valid = txv[5];
   assign rdy = {b5.tx_ready, b4.tx_ready, b3.tx_ready, b2.tx_ready, b1.tx_ready, b0.tx_ready};
   assign rxv = {b5.rx_valid, b4.rx_valid, b3.rx_valid, b2.rx_valid, b1.rx_valid, b0.rx_valid};
   assign rxd[0] = b0.rx_data;  assign rxd[1] = b1.rx_data;  assign rxd[2] = b2.rx_data;
   assign rxd[3] = b3.rx_data;  assign rxd[4] = b4.rx_data;  assign rxd[5] = {4'h0, b5.rx_data};

   function automatic int div_of(input int i);
      return (i >= 1 && i <= 3) ? 3 : 2;
   endfunction

   // ---------------- monitor (sole writer of the counters below) ----------------
   int cs_low[N], rise[N], tog[N], nrx[N], stab_err[N], run_len[N], hi_cnt[N], last_hi[N];
   logic [15:0] seq[N], rx_last[N], rx_prev[N];
   logic [N-1:0] sclk_q = '0, cs_q = '1, mosi_q = '0;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!cs_v[i]) cs_low[i]++;
         if (cs_v[i]) hi_cnt[i]++;
         else if (cs_q[i]) begin last_hi[i] = hi_cnt[i]; hi_cnt[i] = 0; end
         if (sclk_v[i] != sclk_q[i]) begin
            tog[i]++;
            if (sclk_v[i]) rise[i]++;
            // sampling edge: leading for CPHA=0, trailing for CPHA=1
            if ((sclk_q[i] == CPOL_V[i]) != CPHA_V[i]) begin
               seq[i] = {seq[i][14:0], mosi_q[i]};
               if (run_len[i] < div_of(i)) stab_err[i]++;
            end
         end
         if (mosi_v[i] != mosi_q[i]) run_len[i] = 1;
         else run_len[i]++;
         if (rxv[i]) begin nrx[i]++; rx_prev[i] = rx_last[i]; rx_last[i] = rxd[i]; end
      end
      sclk_q = sclk_v;
      cs_q   = cs_v;
      mosi_q = mosi_v;
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;
   int b_cs[N], b_rise[N], b_nrx[N], b_stab[N], b_tog[N];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic take_base(input int i);
      b_cs[i] = cs_low[i]; b_rise[i] = rise[i]; b_nrx[i] = nrx[i];
      b_stab[i] = stab_err[i]; b_tog[i] = tog[i];
   endtask

   task automatic send(input int i, input logic [15:0] d);
      int t;
      @(negedge clk);
      txd[i] = d;
      txv[i] = 1'b1;
      t = 0;
      while (!(rdy[i] && ena_v[i]) && t < 200) begin @(negedge clk); t++; end
      chk($sformatf("accept_u%0d", i), {31'd0, rdy[i]}, 32'd1);
      @(posedge clk);
      #1 txv[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int t;
      t = 0;
      while (busy_v[i] && t < 2000) begin @(negedge clk); t++; end
      chk($sformatf("done_u%0d", i), {31'd0, busy_v[i]}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, frz;
      logic e;
      logic [3:0] p;
      rst_v = '1; ena_v = '1; txv = '0;
      for (int i = 0; i < N; i++) txd[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n",     {31'd0, cs_v[0]},   32'd1);
      chk("rst_sclk",     {31'd0, sclk_v[0]}, 32'd0);
      chk("rst_sclk_cpol1", {31'd0, sclk_v[2]}, 32'd1);
      chk("rst_mosi",     {31'd0, mosi_v[0]}, 32'd0);
      chk("rst_tx_ready", {31'd0, rdy[0]},    32'd0);
      chk("rst_rx_valid", {31'd0, rxv[0]},    32'd0);
      chk("rst_rx_data",  {16'd0, rxd[0]},    32'd0);
      chk("rst_busy",     {31'd0, busy_v[0]}, 32'd0);
      rst_v = '0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, rdy[0]}, 32'd1);

      // defaults, 16'hA5C3 looped back
      #1 take_base(0);
      send(0, 16'hA5C3);
      wait_done(0);
      chk("idle_ready_low", {31'd0, rdy[0]}, 32'd0);
      @(negedge clk);
      chk("idle_ready_high", {31'd0, rdy[0]}, 32'd1);
      #2;
      chk("a5c3_cs_low", cs_low[0] - b_cs[0], 32'd66);
      chk("a5c3_rises",  rise[0] - b_rise[0], 32'd16);
      chk("a5c3_mosi",   {16'd0, seq[0]},     32'h0000A5C3);
      chk("a5c3_rx",     {16'd0, rxd[0]},     32'h0000A5C3);
      chk("a5c3_nrx",    nrx[0] - b_nrx[0],   32'd1);
      chk("a5c3_stab",   stab_err[0] - b_stab[0], 32'd0);

      // modes 1..3, DIV=3, all three in parallel
      for (int i = 1; i <= 3; i++) begin
         take_base(i);
         chk($sformatf("idle_sclk_u%0d", i), {31'd0, sclk_v[i]}, {31'd0, CPOL_V[i]});
      end
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin txd[i] = 16'h8001; txv[i] = 1'b1; end
      t = 0;
      while (!rdy[1] && t < 200) begin @(negedge clk); t++; end
      @(posedge clk);
      #1 txv = '0;
      wait_done(1);
      @(negedge clk);
      #2;
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("mode_rx_u%0d", i),    {16'd0, rxd[i]}, 32'h00008001);
         chk($sformatf("mode_mosi_u%0d", i),  {16'd0, seq[i]}, 32'h00008001);
         chk($sformatf("mode_stab_u%0d", i),  stab_err[i] - b_stab[i], 32'd0);
         chk($sformatf("mode_rises_u%0d", i), rise[i] - b_rise[i], 32'd16);
         chk($sformatf("mode_cs_low_u%0d", i), cs_low[i] - b_cs[i], 32'd98);
         chk($sformatf("mode_nrx_u%0d", i),   nrx[i] - b_nrx[i], 32'd1);
         chk($sformatf("end_sclk_u%0d", i),   {31'd0, sclk_v[i]}, {31'd0, CPOL_V[i]});
      end

      // ena toggling every cycle during a frame
      take_base(0);
      send(0, 16'h8001);
      @(negedge clk);
      frz = 0;
      t = 0;
      while (t < 1000) begin
         p = {sclk_v[0], cs_v[0], mosi_v[0], busy_v[0]};
         e = ~ena_v[0];
         ena_v[0] = e;
         @(negedge clk);
         if (!e && ({sclk_v[0], cs_v[0], mosi_v[0], busy_v[0]} != p)) frz++;
         t++;
         if (!busy_v[0]) break;
      end
      ena_v[0] = 1'b1;
      chk("ena_done", {31'd0, busy_v[0]}, 32'd0);
      #2;
      chk("ena_frozen", frz, 32'd0);
      chk("ena_rx",     {16'd0, rxd[0]}, 32'h00008001);
      chk("ena_cs_low", cs_low[0] - b_cs[0], 32'd132);
      chk("ena_rises",  rise[0] - b_rise[0], 32'd16);
      chk("ena_nrx",    nrx[0] - b_nrx[0],   32'd1);

      // reset at sclk edge 10, then a clean 16'h0F0F frame
      repeat (3) @(negedge clk);
      #1 take_base(0);
      send(0, 16'h3C5A);
      t = 0;
      while ((tog[0] - b_tog[0]) < 10 && t < 500) begin @(negedge clk); #1; t++; end
      rst_v[0] = 1'b1;
      @(negedge clk);
      chk("midrst_cs_n", {31'd0, cs_v[0]},   32'd1);
      chk("midrst_sclk", {31'd0, sclk_v[0]}, 32'd0);
      chk("midrst_mosi", {31'd0, mosi_v[0]}, 32'd0);
      chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
      rst_v[0] = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      chk("midrst_no_rxv", nrx[0] - b_nrx[0], 32'd0);
      take_base(0);
      send(0, 16'h0F0F);
      wait_done(0);
      #2;
      chk("post_rst_rx",     {16'd0, rxd[0]}, 32'h00000F0F);
      chk("post_rst_nrx",    nrx[0] - b_nrx[0], 32'd1);
      chk("post_rst_cs_low", cs_low[0] - b_cs[0], 32'd66);

      // back-to-back with GAP=0, tx_valid held high
      take_base(4);
      @(negedge clk);
      txd[4] = 16'h1234;
      txv[4] = 1'b1;
      t = 0;
      while (!rdy[4] && t < 200) begin @(negedge clk); t++; end
      @(posedge clk);
      #1 txd[4] = 16'hFFFF;
      @(negedge clk);
      t = 0;
      while (!rdy[4] && t < 200) begin @(negedge clk); t++; end
      chk("b2b_second_ready", {31'd0, rdy[4]}, 32'd1);
      @(posedge clk);
      #1 txv[4] = 1'b0;
      wait_done(4);
      #2;
      chk("b2b_nrx",     nrx[4] - b_nrx[4], 32'd2);
      chk("b2b_rx_1",    {16'd0, rx_prev[4]}, 32'h00001234);
      chk("b2b_rx_2",    {16'd0, rx_last[4]}, 32'h0000FFFF);
      chk("b2b_cs_high", last_hi[4], 32'd2);
      chk("b2b_cs_low",  cs_low[4] - b_cs[4], 32'd132);

      // FRAME_W=12, LSB first
      take_base(5);
      send(5, 16'h0801);
      wait_done(5);
      #2;
      chk("w12_mosi",   {20'd0, seq[5][11:0]}, 32'h00000801);
      chk("w12_rx",     {16'd0, rxd[5]},       32'h00000801);
      chk("w12_cs_low", cs_low[5] - b_cs[5],   32'd50);
      chk("w12_rises",  rise[5] - b_rise[5],   32'd12);
      chk("w12_stab",   stab_err[5] - b_stab[5], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
